// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART-loaded program memory that gates CPU reset until a checksummed image is in place
// Optional macro LOADER_ACK_EN: adds uart_tx and an 8N1 transmitter that answers ACK (06) on load success, NAK (15) on error.
module uart_prog_loader #(
  parameter int         CLKS_PER_BIT = 434,
  parameter int         DEPTH        = 256,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        sync_rst,
  input  logic        uart_rx,
  input  logic [15:0] read_pos,
  output logic [7:0]  data,
  output logic        cpu_rst_n,
  output logic        load_busy,
  output logic        load_err,
`ifdef LOADER_ACK_EN
  output logic        uart_tx,
`endif
  output logic [15:0] load_len
);

  localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int              CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [16:0]     DEPTH_W   = 17'(DEPTH);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_LEN_HI, L_LEN_LO, L_DATA, L_CSUM, L_DONE, L_ERROR} ld_state_t;

  // Receiver state
  logic          r_rx_meta, r_rx_sync;
  rx_state_t     r_rx_state, w_rx_state_nxt;
  logic [CW-1:0] r_rx_cnt, w_rx_cnt_nxt;
  logic [2:0]    r_rx_bit, w_rx_bit_nxt;
  logic [7:0]    r_rx_shift, w_rx_shift_nxt;
  logic          r_rx_valid, w_rx_valid_nxt;
  logic          r_rx_ferr, w_rx_ferr_nxt;

  // Loader state
  ld_state_t     r_state, w_state_nxt;
  logic [15:0]   r_len, w_len_nxt;
  logic [15:0]   r_count, w_count_nxt;
  logic [7:0]    r_sum, w_sum_nxt;
  logic [15:0]   r_load_len, w_load_len_nxt;
  logic [15:0]   w_len_full;
  logic          w_mem_we;

  logic [7:0]    r_mem [DEPTH];

  // Two-flop synchronizer; idles high so reset does not look like a start bit
  always_ff @(posedge clk or negedge sync_rst) begin
    if (!sync_rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx;
      r_rx_sync <= r_rx_meta;
    end
  end

  // Receiver state register
  always_ff @(posedge clk or negedge sync_rst) begin
    if (!sync_rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_rx_ferr  <= w_rx_ferr_nxt;
    end
  end

  // Receiver next state: mid-bit sampling, glitch rejection on the start bit, LSB-first shift
  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_valid_nxt = 1'b0;
    w_rx_ferr_nxt  = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (!r_rx_sync) begin
          w_rx_state_nxt = RX_START;
          w_rx_cnt_nxt   = '0;
        end
      end
      RX_START: begin
        if (r_rx_cnt == HALF_LAST) begin
          w_rx_cnt_nxt = '0;
          if (r_rx_sync) begin
            w_rx_state_nxt = RX_IDLE;
          end else begin
            w_rx_state_nxt = RX_DATA;
            w_rx_bit_nxt   = '0;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_ONE;
        end
      end
      RX_DATA: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_sync, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) begin
            w_rx_state_nxt = RX_STOP;
          end else begin
            w_rx_bit_nxt = r_rx_bit + 3'd1;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_ONE;
        end
      end
      RX_STOP: begin
        if (r_rx_cnt == BIT_LAST) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = RX_IDLE;
          if (r_rx_sync) begin
            w_rx_valid_nxt = 1'b1;
          end else begin
            w_rx_ferr_nxt = 1'b1;
          end
        end else begin
          w_rx_cnt_nxt = r_rx_cnt + CNT_ONE;
        end
      end
      default: w_rx_state_nxt = RX_IDLE;
    endcase
  end

  assign w_len_full = {r_len[15:8], r_rx_shift};

  // Loader state register
  always_ff @(posedge clk or negedge sync_rst) begin
    if (!sync_rst) begin
      r_state    <= L_IDLE;
      r_len      <= '0;
      r_count    <= '0;
      r_sum      <= '0;
      r_load_len <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_len      <= w_len_nxt;
      r_count    <= w_count_nxt;
      r_sum      <= w_sum_nxt;
      r_load_len <= w_load_len_nxt;
    end
  end

  // Loader next state: frame parsing, length bound, running checksum
  always_comb begin
    w_state_nxt    = r_state;
    w_len_nxt      = r_len;
    w_count_nxt    = r_count;
    w_sum_nxt      = r_sum;
    w_load_len_nxt = r_load_len;
    w_mem_we       = 1'b0;
    case (r_state)
      L_IDLE, L_DONE, L_ERROR: begin
        if (r_rx_valid && (r_rx_shift == SYNC_BYTE)) begin
          w_state_nxt = L_LEN_HI;
        end
      end
      L_LEN_HI: begin
        if (r_rx_ferr) begin
          w_state_nxt = L_ERROR;
        end else if (r_rx_valid) begin
          w_len_nxt   = {r_rx_shift, r_len[7:0]};
          w_state_nxt = L_LEN_LO;
        end
      end
      L_LEN_LO: begin
        if (r_rx_ferr) begin
          w_state_nxt = L_ERROR;
        end else if (r_rx_valid) begin
          w_len_nxt   = w_len_full;
          w_count_nxt = '0;
          w_sum_nxt   = '0;
          if ({1'b0, w_len_full} > DEPTH_W) begin
            w_state_nxt = L_ERROR;
          end else if (w_len_full == 16'd0) begin
            w_state_nxt = L_CSUM;
          end else begin
            w_state_nxt = L_DATA;
          end
        end
      end
      L_DATA: begin
        if (r_rx_ferr) begin
          w_state_nxt = L_ERROR;
        end else if (r_rx_valid) begin
          w_mem_we    = 1'b1;
          w_sum_nxt   = r_sum + r_rx_shift;
          w_count_nxt = r_count + 16'd1;
          if ((r_count + 16'd1) == r_len) begin
            w_state_nxt = L_CSUM;
          end
        end
      end
      L_CSUM: begin
        if (r_rx_ferr) begin
          w_state_nxt = L_ERROR;
        end else if (r_rx_valid) begin
          if (r_rx_shift == r_sum) begin
            w_state_nxt    = L_DONE;
            w_load_len_nxt = r_len;
          end else begin
            w_state_nxt = L_ERROR;
          end
        end
      end
      default: w_state_nxt = L_IDLE;
    endcase
  end

  // Program memory write port; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_count[AW-1:0]] <= r_rx_shift;
    end
  end

  // Out-of-range fetches return the halt opcode so a runaway CPU stops
  assign data      = ({1'b0, read_pos} < DEPTH_W) ? r_mem[read_pos[AW-1:0]] : 8'h1F;
  assign cpu_rst_n = (r_state == L_DONE);
  assign load_busy = (r_state == L_LEN_HI) || (r_state == L_LEN_LO) ||
                     (r_state == L_DATA)   || (r_state == L_CSUM);
  assign load_err  = (r_state == L_ERROR);
  assign load_len  = r_load_len;

`ifdef LOADER_ACK_EN
  logic          r_tx_busy;
  logic [9:0]    r_tx_shift;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bit;
  logic          w_tx_start;
  logic [7:0]    w_tx_byte;

  assign w_tx_start = ((w_state_nxt == L_DONE)  && (r_state != L_DONE)) ||
                      ((w_state_nxt == L_ERROR) && (r_state != L_ERROR));
  assign w_tx_byte  = (w_state_nxt == L_DONE) ? 8'h06 : 8'h15;

  // Reply transmitter; a byte in flight always completes, a result arriving meanwhile is dropped
  always_ff @(posedge clk or negedge sync_rst) begin
    if (!sync_rst) begin
      r_tx_busy  <= 1'b0;
      r_tx_shift <= '1;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
    end else if (!r_tx_busy) begin
      if (w_tx_start) begin
        r_tx_busy  <= 1'b1;
        r_tx_shift <= {1'b1, w_tx_byte, 1'b0};
        r_tx_cnt   <= '0;
        r_tx_bit   <= '0;
      end
    end else if (r_tx_cnt == BIT_LAST) begin
      r_tx_cnt   <= '0;
      r_tx_shift <= {1'b1, r_tx_shift[9:1]};
      if (r_tx_bit == 4'd9) begin
        r_tx_busy <= 1'b0;
      end else begin
        r_tx_bit <= r_tx_bit + 4'd1;
      end
    end else begin
      r_tx_cnt <= r_tx_cnt + CNT_ONE;
    end
  end

  assign uart_tx = r_tx_busy ? r_tx_shift[0] : 1'b1;
`endif

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - self-checking bench for uart_prog_loader (CLKS_PER_BIT=4, DEPTH=16)
module tb_uart_prog_loader;
  localparam int CPB = 4;
  localparam int DEP = 16;

  typedef logic [7:0] byte_q_t [$];
  typedef struct {
    logic [15:0] pos;
    logic [7:0]  exp;
  } rd_vec_t;

  logic        clk = 1'b0;
  logic        sync_rst;
  logic        uart_rx;
  logic [15:0] read_pos;
  logic [7:0]  data;
  logic        cpu_rst_n;
  logic        load_busy;
  logic        load_err;
  logic [15:0] load_len;
`ifdef LOADER_ACK_EN
  logic        uart_tx;
`endif

  always #5 clk = ~clk;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .DEPTH(DEP), .SYNC_BYTE(8'hA5)) dut (
    .clk       (clk),
    .sync_rst  (sync_rst),
    .uart_rx   (uart_rx),
    .read_pos  (read_pos),
    .data      (data),
    .cpu_rst_n (cpu_rst_n),
    .load_busy (load_busy),
    .load_err  (load_err),
`ifdef LOADER_ACK_EN
    .uart_tx   (uart_tx),
`endif
    .load_len  (load_len)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what the memory and status should look like after each whole frame
  logic [7:0]  m_mem [DEP];
  bit          m_known [DEP];
  logic        m_run;
  logic        m_err;
  logic [15:0] m_len;

  rd_vec_t rd_tab [6];
  byte_q_t q;
  byte_q_t empty_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(CPB);
    end
    uart_rx = stop_bit;
    tick(CPB);
    uart_rx = 1'b1;
    tick(CPB);
  endtask

  task automatic send_seq(input byte_q_t bq);
    foreach (bq[i]) send_byte(bq[i], 1'b1);
  endtask

  task automatic model_load(input int len, input byte_q_t d, input logic [7:0] csum);
    logic [7:0] s;
    s = 8'h00;
    if (len > DEP) begin
      m_err = 1'b1;
      m_run = 1'b0;
      return;
    end
    for (int i = 0; i < len; i++) begin
      m_mem[i]   = d[i];
      m_known[i] = 1'b1;
      s          = s + d[i];
    end
    if (csum == s) begin
      m_run = 1'b1;
      m_err = 1'b0;
      m_len = 16'(len);
    end else begin
      m_run = 1'b0;
      m_err = 1'b1;
    end
  endtask

  task automatic run_frame(input logic [15:0] len, input byte_q_t d, input logic [7:0] csum);
    send_byte(8'hA5, 1'b1);
    send_byte(len[15:8], 1'b1);
    send_byte(len[7:0], 1'b1);
    if (int'(len) <= DEP) begin
      foreach (d[i]) send_byte(d[i], 1'b1);
      send_byte(csum, 1'b1);
    end
    model_load(int'(len), d, csum);
  endtask

  task automatic check_model(input string tag);
    logic [15:0] p;
    check({tag, " cpu_rst_n"}, 32'(cpu_rst_n), 32'(m_run));
    check({tag, " load_busy"}, 32'(load_busy), 32'd0);
    check({tag, " load_err"},  32'(load_err),  32'(m_err));
    check({tag, " load_len"},  32'(load_len),  32'(m_len));
    for (int a = 0; a < DEP + 2; a++) begin
      read_pos = 16'(a);
      @(negedge clk);
      if (a >= DEP) check($sformatf("%s rd[%0d]", tag, a), 32'(data), 32'h1F);
      else if (m_known[a]) check($sformatf("%s rd[%0d]", tag, a), 32'(data), 32'(m_mem[a]));
    end
    p = 16'($urandom_range(DEP, 65535));
    read_pos = p;
    @(negedge clk);
    check($sformatf("%s rd[%0d]", tag, p), 32'(data), 32'h1F);
    tick(1);
  endtask

  task automatic check_status(input string tag, input logic cr, input logic bz, input logic er, input logic [15:0] ln);
    check({tag, " cpu_rst_n"}, 32'(cpu_rst_n), 32'(cr));
    check({tag, " load_busy"}, 32'(load_busy), 32'(bz));
    check({tag, " load_err"},  32'(load_err),  32'(er));
    check({tag, " load_len"},  32'(load_len),  32'(ln));
  endtask

  initial begin
    int          len;
    logic [7:0]  s;
    logic [7:0]  cs;
    logic [7:0]  b;

    rd_tab[0] = '{16'd0,      8'h11};
    rd_tab[1] = '{16'd1,      8'h22};
    rd_tab[2] = '{16'd2,      8'h33};
    rd_tab[3] = '{16'd16,     8'h1F};
    rd_tab[4] = '{16'd256,    8'h1F};
    rd_tab[5] = '{16'hFFFF,   8'h1F};

    m_run = 1'b0;
    m_err = 1'b0;
    m_len = 16'd0;
    for (int i = 0; i < DEP; i++) m_known[i] = 1'b0;

    sync_rst = 1'b0;
    uart_rx  = 1'b1;
    read_pos = 16'd0;
    tick(3);
    check_status("reset", 1'b0, 1'b0, 1'b0, 16'd0);
    sync_rst = 1'b1;
    tick(3);

    // Garbage in IDLE
    q = {8'h00, 8'hFF, 8'h5A};
    send_seq(q);
    check_status("idle garbage", 1'b0, 1'b0, 1'b0, 16'd0);

    // Frame A, checked before and after the checksum byte
    q = {8'hA5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
    send_seq(q);
    check_status("frameA pre-csum", 1'b0, 1'b1, 1'b0, 16'd0);
    send_byte(8'h66, 1'b1);
    check_status("frameA done", 1'b1, 1'b0, 1'b0, 16'd3);
    q = {8'h11, 8'h22, 8'h33};
    model_load(3, q, 8'h66);

    for (int i = 0; i < 6; i++) begin
      read_pos = rd_tab[i].pos;
      @(negedge clk);
      check($sformatf("rd_tab[%0d]", i), 32'(data), 32'(rd_tab[i].exp));
    end
    tick(1);

    // Garbage in DONE must not disturb the running CPU
    q = {8'h00, 8'hFF, 8'h5A};
    send_seq(q);
    check_status("done garbage", 1'b1, 1'b0, 1'b0, 16'd3);

    // Bad checksum
    q = {8'h10, 8'h20};
    run_frame(16'd2, q, 8'h31);
    check_status("bad csum", 1'b0, 1'b0, 1'b1, 16'd3);
    check_model("bad csum");

    // Oversize length, then an empty image
    run_frame(16'h0020, empty_q, 8'h00);
    check_status("oversize", 1'b0, 1'b0, 1'b1, 16'd3);
    run_frame(16'd0, empty_q, 8'h00);
    check_status("empty image", 1'b1, 1'b0, 1'b0, 16'd0);
    check_model("empty image");

    // Framing error on the second data byte
    q = {8'hA5, 8'h00, 8'h03, 8'hAA};
    send_seq(q);
    send_byte(8'hBB, 1'b0);
    m_mem[0] = 8'hAA; m_known[0] = 1'b1;
    m_run = 1'b0; m_err = 1'b1;
    check_status("stop err", 1'b0, 1'b0, 1'b1, 16'd0);
    check_model("stop err");
    q = {8'h00, 8'hFF, 8'h5A};
    send_seq(q);
    check_model("error garbage");

    // One-cycle glitch while waiting for LEN_HI must not be taken as a byte
    send_byte(8'hA5, 1'b1);
    check_status("glitch pre", 1'b0, 1'b1, 1'b0, 16'd0);
    uart_rx = 1'b0;
    tick(1);
    uart_rx = 1'b1;
    tick(3 * CPB);
    q = {8'h00, 8'h01, 8'h5C, 8'h5C};
    send_seq(q);
    q = {8'h5C};
    model_load(1, q, 8'h5C);
    check_model("glitch");

    // Re-load from DONE: CPU reset drops on the sync byte and returns after the checksum
    send_byte(8'hA5, 1'b1);
    check_status("reload sync", 1'b0, 1'b1, 1'b0, 16'd1);
    q = {8'h00, 8'h01, 8'h7E, 8'h7E};
    send_seq(q);
    q = {8'h7E};
    model_load(1, q, 8'h7E);
    read_pos = 16'd0;
    @(negedge clk);
    check("reload rd0", 32'(data), 32'h7E);
    tick(1);
    check_model("reload");

    // Asynchronous reset in the middle of DATA
    q = {8'hA5, 8'h00, 8'h05, 8'h01, 8'h02};
    send_seq(q);
    check_status("mid data", 1'b0, 1'b1, 1'b0, 16'd1);
    #3;
    sync_rst = 1'b0;
    #1;
    check_status("async reset", 1'b0, 1'b0, 1'b0, 16'd0);
    m_mem[0] = 8'h01; m_mem[1] = 8'h02;
    m_run = 1'b0; m_err = 1'b0; m_len = 16'd0;
    tick(2);
    sync_rst = 1'b1;
    tick(2);
    check_model("after reset");
    q = {8'h00, 8'hFF, 8'h5A};
    send_seq(q);
    check_model("reset garbage");

    // Random frames against the model
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 9) == 0) len = $urandom_range(DEP + 1, 65535);
      else len = $urandom_range(0, DEP);
      q = {};
      s = 8'h00;
      if (len <= DEP) begin
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom);
          q.push_back(b);
          s = s + b;
        end
      end
      cs = s;
      if ($urandom_range(0, 3) == 0) cs = s ^ 8'($urandom_range(1, 255));
      run_frame(16'(len), q, cs);
      check_model($sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Program-memory stage that sits directly upstream of the CPU's instruction fetch.
- Receives a framed program image over UART 8N1 and stores it in an internal byte memory.
- Serves that memory to the CPU through the same fetch interface the CPU already uses: read_pos in, data out, combinational.
- Holds the CPU in reset via cpu_rst_n until a complete image with a valid checksum has been loaded.

Parameters:
- CLKS_PER_BIT, 434: clk cycles per UART bit (50 MHz / 115200). Legal range is 4 or more.
- DEPTH, 256: program memory size in bytes. Legal range is 1..65535.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- clk  input  1  system clock, rising edge
- sync_rst  input  1  reset, asynchronous, active-low
- uart_rx  input  1  serial input, idle high, asynchronous to clk
- read_pos  input  16  CPU fetch address
- data  output  8  fetched byte, combinational from read_pos
- cpu_rst_n  output  1  active-low reset to the CPU; low while no valid image is present
- load_busy  output  1  high from sync byte accepted until DONE or ERROR
- load_err  output  1  high while in ERROR
- load_len  output  16  length of the last successfully loaded image

Behaviour:
- Reset: all outputs go low immediately and asynchronously, including cpu_rst_n, load_busy, load_err and load_len (load_len=0).
  - uart_rx synchronizer resets to 1.
  - FSM goes to IDLE and the RX FSM goes to RX_IDLE.
  - Memory contents are not cleared.
  - Reset mid-load abandons the frame.
- RX path:
  - 2-flop synchronizer on uart_rx.
  - Falling edge in RX_IDLE starts RX_START.
  - Line is sampled at CLKS_PER_BIT/2; if it is high, the edge is a glitch and the RX FSM returns to RX_IDLE.
  - Then RX_DATA: 8 bits, LSB first, each sampled CLKS_PER_BIT after the previous sample.
  - Then RX_STOP.
  - Stop bit=1: 1-cycle rx_valid pulse with rx_byte.
  - Stop bit=0: 1-cycle rx_ferr pulse, byte discarded.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, LEN data bytes, CSUM.
  - CSUM = 8-bit sum of the data bytes, mod 256.
  - CSUM does not include the sync or length bytes.
- Loader FSM:
  - IDLE / DONE / ERROR: on rx_valid with byte==SYNC_BYTE → LEN_HI.
    - On entry: cpu_rst_n=0, load_busy=1, load_err=0.
    - Other bytes and rx_ferr are ignored.
  - LEN_HI: on rx_valid, latch len[15:8] → LEN_LO.
  - LEN_LO: on rx_valid, latch len[7:0].
    - len > DEPTH → ERROR.
    - len == 0 → CSUM.
    - Otherwise clear the count and go to DATA.
  - DATA: on rx_valid, write mem[count] <= byte, sum += byte, count++.
    - After byte number len is written → CSUM.
    - The written byte is visible on data the cycle after rx_valid.
  - CSUM: on rx_valid, compare byte with sum.
    - Match → DONE: load_len=len, load_busy=0, cpu_rst_n=1 on the cycle after rx_valid.
    - Mismatch → ERROR: load_err=1, load_busy=0, cpu_rst_n stays 0.
  - rx_ferr in LEN_HI, LEN_LO, DATA or CSUM → ERROR.
- Read port:
  - data = mem[read_pos] when read_pos < DEPTH.
  - Otherwise data = 8'h1F, the halt opcode, so runaway fetches stop the CPU.
  - Addresses at or above load_len but below DEPTH return stale contents.
- Simultaneous events: a memory write and a read of the same address in the same cycle return the old byte. The CPU is in reset during DATA, so this case is not functional.
- A re-load from DONE asserts cpu_rst_n=0 on the cycle after the sync byte's rx_valid.

Optional Feature:
- Macro: LOADER_ACK_EN.
- Defined:
  - Adds output uart_tx (1 bit, idle 1, reset 1).
  - Adds an 8N1 transmitter at CLKS_PER_BIT.
  - On entering DONE it sends 8'h06 (ACK); on entering ERROR it sends 8'h15 (NAK).
  - A new sync byte during transmission does not abort the transmitted byte.
- Undefined: no uart_tx port and no transmitter logic.

Test Plan (CLKS_PER_BIT=4, DEPTH=16):
- Frame A5 00 03 11 22 33 66 → DONE, load_len=3, cpu_rst_n 0→1 one cycle after the last stop bit's sample. read_pos 0/1/2 → 11/22/33; read_pos 16 → 1F.
- Frame A5 00 02 10 20 31 (bad CSUM) → load_err=1, cpu_rst_n=0, load_len unchanged. With LOADER_ACK_EN, uart_tx sends 15.
- Frame A5 00 20 → ERROR right after LEN_LO (32 > DEPTH). Then A5 00 00 00 → DONE, load_len=0.
- Stop bit forced to 0 on the second data byte → ERROR. Garbage bytes 00 FF 5A in IDLE → no state change.
- A 1-cycle low glitch on uart_rx in RX_IDLE → no rx_valid. Assert sync_rst mid-DATA → all outputs 0 immediately, FSM back in IDLE.
- After a successful load, send A5 00 01 7E 7E → cpu_rst_n drops on the sync byte, rises again, and read_pos 0 → 7E.
